// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the screen sequencer: default screen indices, default key mask,
// and an elaboration-time clog2 helper.
package screen_seq_pkg;

  typedef enum logic [2:0] {
    SCR_START = 3'd0,
    SCR_ERASE = 3'd1,
    SCR_GRID  = 3'd2,
    SCR_PLAY  = 3'd3,
    SCR_END   = 3'd4
  } screen_e;

  localparam int         DEF_NUM_SCREENS = 5;
  localparam logic [4:0] DEF_KEY_MASK    = 5'b10001;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Control and display-path bundle of the screen sequencer. The master side is the
// sequencer itself; the slave side is the game logic / drawer mux that consumes it.
interface screen_sequencer_if #(
  parameter int NUM_SCREENS = 5,
  parameter int SEL_W       = 3,
  parameter int CNT_W       = 8
);

  logic                   enable;
  logic                   restart;
  logic                   input_key;
  logic [NUM_SCREENS-1:0] done;
  logic [SEL_W-1:0]       display_sel_out;
  logic [NUM_SCREENS-1:0] screen_en;
  logic                   screen_start;
  logic [CNT_W-1:0]       round_count;
  logic                   timeout;

  modport master (
    input  enable, restart, input_key, done,
    output display_sel_out, screen_en, screen_start, round_count, timeout
  );

  modport slave (
    output enable, restart, input_key, done,
    input  display_sel_out, screen_en, screen_start, round_count, timeout
  );

endinterface

// File: rtl/screen_sequencer_onehot_decoder.sv
// Binary index to one-hot decoder; an out-of-range index decodes to all zeros.
// Shared between the sequencer's screen enables and the drawer mux.
module onehot_decoder #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [W-1:0] sel_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == W'(i)) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Top-level screen sequencer: steps through NUM_SCREENS screens on key edges or drawer done flags.
// Optional per-screen watchdog enabled by defining WATCHDOG_EN.
module screen_sequencer
  import screen_seq_pkg::*;
#(
  parameter int                     NUM_SCREENS    = DEF_NUM_SCREENS,
  parameter int                     SEL_W          = 3,
  parameter logic [NUM_SCREENS-1:0] KEY_MASK       = DEF_KEY_MASK,
  parameter int                     CNT_W          = 8,
  parameter int                     TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                resetn,
  screen_sequencer_if.master  bus
);

  localparam int                  SEL_SPAN     = 1 << SEL_W;
  localparam logic [SEL_W-1:0]    LAST_SCREEN  = SEL_W'(NUM_SCREENS - 1);
  localparam logic [SEL_SPAN-1:0] KEY_MASK_PAD = SEL_SPAN'(KEY_MASK);

  if (NUM_SCREENS < 2 || NUM_SCREENS > 16 || SEL_SPAN < NUM_SCREENS || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("screen_sequencer: illegal parameter combination");
  end

  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                start_q, start_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    round_q, round_d;
  logic                key_q;
  logic [SEL_SPAN-1:0] donePad;
  logic                keyRise, keyDriven, inRange, adv, wdFire;

  assign donePad   = SEL_SPAN'(bus.done);
  assign keyRise   = bus.input_key & ~key_q;
  assign keyDriven = KEY_MASK_PAD[sel_q];
  assign inRange   = (sel_q <= LAST_SCREEN);
  assign adv       = bus.enable & (keyDriven ? keyRise : donePad[sel_q]);

`ifdef WATCHDOG_EN
  localparam int WD_W = (clog2(TIMEOUT_CYCLES) < 1) ? 1 : clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  assign wdFire = bus.enable & ~keyDriven & ~adv & (wd_q == WD_LIMIT);

  // Counter saturates at the limit so key-driven screens can idle forever without wrapping.
  always_comb begin
    wd_d = wd_q;
    if (start_d) begin
      wd_d = '0;
    end else if (bus.enable && wd_q != WD_LIMIT) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  assign wdFire = 1'b0;
`endif

  // Restart beats everything; an out-of-range select recovers even while disabled.
  always_comb begin
    sel_d     = sel_q;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    round_d   = round_q;
    if (bus.restart || !inRange) begin
      sel_d   = '0;
      start_d = 1'b1;
    end else if (adv || wdFire) begin
      start_d   = 1'b1;
      timeout_d = wdFire;
      if (sel_q == LAST_SCREEN) begin
        sel_d = '0;
        if (round_q != '1) round_d = round_q + CNT_W'(1);
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sel_q     <= SEL_W'(SCR_START);
      start_q   <= 1'b1;
      timeout_q <= 1'b0;
      round_q   <= '0;
      key_q     <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      round_q   <= round_d;
      key_q     <= bus.input_key;
    end
  end

  onehot_decoder #(
    .N (NUM_SCREENS),
    .W (SEL_W)
  ) u_screen_dec (
    .sel_i    (sel_q),
    .onehot_o (bus.screen_en)
  );

  assign bus.display_sel_out = sel_q;
  assign bus.screen_start    = start_q;
  assign bus.round_count     = round_q;
  assign bus.timeout         = timeout_q;

endmodule
